// File: rtl/sail_stdout_arbiter.sv
// sail_stdout_arbiter: round-robin sharing of one stdout byte sink between N_REQ message sources.
// Optional SAIL_PRINT_ENDLINE_EN appends 0x0A after every message.
module sail_stdout_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_MSG_LEN = 256
) (
  input  logic               in_clk,
  input  logic               in_reset_n,
  input  logic [N_REQ-1:0]   in_req_valid,
  input  logic [8*N_REQ-1:0] in_req_data,
  input  logic [N_REQ-1:0]   in_req_last,
  output logic [N_REQ-1:0]   out_req_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_last,
  input  logic               in_ready,
  output logic [N_REQ-1:0]   out_grant,
  output logic               out_busy,
  output logic               out_trunc
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_MSG_LEN + 1);
`ifdef SAIL_PRINT_ENDLINE_EN
  localparam bit ENDLINE = 1'b1;
`else
  localparam bit ENDLINE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, STREAM, NEWLINE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, g_idx, sel;
  logic [CW-1:0] cnt;
  logic slot_free, accept, byte_last, trunc, msg_end, arb, rel;
  logic [7:0] byte_data;
  // scan downwards so the lowest offset from ptr wins
  always_comb begin
    sel = ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (in_req_valid[(int'(ptr) + i) % N_REQ]) sel = PW'((int'(ptr) + i) % N_REQ);
  end
  assign slot_free     = !out_valid || in_ready;
  assign out_req_ready = (state == STREAM && slot_free) ? out_grant : '0;
  assign byte_data     = in_req_data[8*g_idx +: 8];
  assign byte_last     = in_req_last[g_idx];
  assign accept        = state == STREAM && slot_free && in_req_valid[g_idx];
  assign trunc         = accept && !byte_last && cnt == CW'(MAX_MSG_LEN - 1);
  assign msg_end       = accept && (byte_last || trunc);
  assign arb           = state == IDLE && |in_req_valid;
  assign rel           = state != IDLE && state_nx == IDLE;
  assign out_busy      = state != IDLE;
  always_comb begin
    state_nx = state;
    if (arb) state_nx = STREAM;
    else if (msg_end) state_nx = ENDLINE ? NEWLINE : IDLE;
    else if (state == NEWLINE && slot_free) state_nx = IDLE;
  end
  always_ff @(posedge in_clk or negedge in_reset_n)
    if (!in_reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g_idx     <= '0;
      cnt       <= '0;
      out_grant <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      state     <= state_nx;
      out_trunc <= trunc;
      if (arb) begin
        out_grant <= N_REQ'(1) << sel;
        g_idx     <= sel;
      end else if (rel) begin
        out_grant <= '0;
        ptr       <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
      if (accept) cnt <= msg_end ? '0 : cnt + 1'b1;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= byte_data;
        out_last  <= !ENDLINE && (byte_last || trunc);
      end else if (state == NEWLINE && slot_free) begin
        out_valid <= 1'b1;
        out_data  <= 8'h0A;
        out_last  <= 1'b1;
      end else if (in_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sail_stdout_arbiter.sv
// tb_sail_stdout_arbiter: scoreboard bench for sail_stdout_arbiter (N_REQ=4, MAX_MSG_LEN=4).
module tb_sail_stdout_arbiter;
  localparam int N = 4;
  localparam int MAXL = 4;
`ifdef SAIL_PRINT_ENDLINE_EN
  localparam bit EL = 1'b1;
`else
  localparam bit EL = 1'b0;
`endif
  logic in_clk = 1'b0, in_reset_n = 1'b0, in_ready = 1'b1;
  logic [N-1:0] in_req_valid = '0, in_req_last = '0;
  logic [8*N-1:0] in_req_data = '0;
  logic [N-1:0] out_req_ready, out_grant, prev_grant;
  logic out_valid, out_last, out_busy, out_trunc;
  logic [7:0] out_data;
  int errors = 0, checks = 0, trunc_seen = 0, trunc_exp = 0;
  int mcnt[N];
  logic [9:0] exp_q[$];
  int gr_q[$];

  sail_stdout_arbiter #(.N_REQ(N), .MAX_MSG_LEN(MAXL)) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_req_valid(in_req_valid),
    .in_req_data(in_req_data), .in_req_last(in_req_last), .out_req_ready(out_req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .in_ready(in_ready),
    .out_grant(out_grant), .out_busy(out_busy), .out_trunc(out_trunc)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    if (EL && l) begin
      exp_q.push_back({2'b00, d});
      exp_q.push_back({2'b01, 8'h0A});
    end else
      exp_q.push_back({1'b0, l, d});
  endtask

  // one message from requester r: n bytes base, base+1, ...; last flag on the final byte
  task automatic send(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      int t;
      logic tr, l;
      in_req_valid[r] = 1'b1;
      in_req_data[8*r +: 8] = base + 8'(k);
      in_req_last[r] = (k == n - 1);
      t = 0;
      do begin
        @(negedge in_clk);
        t++;
      end while (!out_req_ready[r] && t < 200);
      if (!out_req_ready[r]) begin
        chk("accept_timeout", 32'(out_req_ready[r]), 1);
        break;
      end
      mcnt[r]++;
      tr = (mcnt[r] == MAXL) && (k != n - 1);
      l = tr || (k == n - 1);
      if (tr) trunc_exp++;
      if (l) mcnt[r] = 0;
      push_byte(base + 8'(k), l);
      @(posedge in_clk);
      #1;
    end
    in_req_valid[r] = 1'b0;
    in_req_last[r] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_order(input int n, input logic [31:0] exp);
    logic [31:0] got;
    got = 0;
    foreach (gr_q[i]) got = (got << 4) | 32'(gr_q[i]);
    chk("grant_count", gr_q.size(), 32'(n));
    chk("grant_order", got, exp);
    gr_q.delete();
  endtask

  task automatic reset_dut();
    in_reset_n = 1'b0;
    in_req_valid = '0;
    in_req_last = '0;
    in_ready = 1'b1;
    foreach (mcnt[i]) mcnt[i] = 0;
    @(posedge in_clk);
    #1;
    in_reset_n = 1'b1;
  endtask

  always @(negedge in_clk)
    if (!in_reset_n) prev_grant = '0;
    else begin
      if (out_valid && in_ready)
        chk("out_byte", {22'd0, out_last, out_data},
            exp_q.size() != 0 ? {22'd0, exp_q.pop_front()} : 32'h200);
      if (out_trunc) trunc_seen++;
      if (out_grant != 0 && prev_grant == 0)
        for (int i = 0; i < N; i++) if (out_grant[i]) gr_q.push_back(i);
      prev_grant = out_grant;
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // reset behaviour and first-message latency
    in_req_valid[0] = 1'b1;
    in_req_data[7:0] = 8'h41;
    in_req_last[0] = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_grant", 32'(out_grant), 0);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_trunc", 32'(out_trunc), 0);
    chk("rst_ready", 32'(out_req_ready), 0);
    in_reset_n = 1'b1;
    @(posedge in_clk);
    #1;
    chk("arb_grant", 32'(out_grant), 1);
    chk("arb_busy", 32'(out_busy), 1);
    chk("arb_ready", 32'(out_req_ready), 1);
    push_byte(8'h41, 1'b1);
    @(posedge in_clk);
    #1;
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h41);
    chk("lat_last", 32'(out_last), 32'(!EL));
    chk("lat_grant", 32'(out_grant), EL ? 1 : 0);
    in_req_valid = '0;
    in_req_last = '0;
    drain();
    // round robin across all four requesters
    reset_dut();
    gr_q.delete();
    fork
      begin send(0, 2, 8'h10); send(0, 2, 8'h18); end
      send(1, 2, 8'h20);
      send(2, 2, 8'h30);
      send(3, 2, 8'h40);
    join
    drain();
    chk_order(5, 32'h01230);
    // sink back-pressure
    fork
      send(2, 2, 8'h68);
      begin
        logic [6:0] pat;
        pat = 7'b1001001;
        for (int k = 6; k >= 0; k--) begin
          in_ready = pat[k];
          @(posedge in_clk);
          #1;
        end
        in_ready = 1'b1;
      end
    join
    drain();
    gr_q.delete();
    // truncation at MAX_MSG_LEN
    send(1, 6, 8'h30);
    drain();
    chk("trunc_pulses", trunc_seen, trunc_exp);
    chk_order(2, 32'h11);
    // asynchronous reset with a held output byte
    in_ready = 1'b0;
    in_req_valid[3] = 1'b1;
    in_req_data[31:24] = 8'h77;
    in_req_last[3] = 1'b0;
    t = 0;
    do begin
      @(negedge in_clk);
      t++;
    end while (!out_valid && t < 50);
    chk("held_valid", 32'(out_valid), 1);
    #2;
    in_reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_grant", 32'(out_grant), 0);
    chk("async_busy", 32'(out_busy), 0);
    chk("async_ready", 32'(out_req_ready), 0);
    reset_dut();
    gr_q.delete();
    fork
      send(0, 1, 8'h55);
      send(3, 1, 8'h66);
    join
    drain();
    chk_order(2, 32'h03);
    // back-to-back single-byte messages from neighbours
    fork
      send(0, 1, 8'h41);
      send(1, 1, 8'h42);
    join
    drain();
    chk_order(2, 32'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
